odu_gen_data_mc: RTL

- Parametrised, multi-channel successor to the single-stream ODU data generator.
- Produces ODU-style row/frame-structured test words for up to CH_NUM logical channels, interleaved round-robin on one output bus.
- Per-channel enable mask, count/fixed pattern modes, programmable row/frame geometry, programmable inter-word gap, and per-channel sequence state that survives pausing.
- Configured over the existing async-style cfg bus (cs/we/oe, address, 16-bit data). Feeds downstream ODU framer/checker logic.

---
 rtl/odu_gen_data_mc_if.sv | 27 ++
 rtl/odu_gen_data_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/odu_gen_data_mc_if.sv
// Config bus and data output bundle for the multi-channel ODU data generator.
// The master side drives the cfg strobes; the slave side (the generator)
// returns read data, the channel ID and the {valid, fs, rs, payload} word.
interface odu_gen_data_mc_if #(
  parameter int DATA_W = 384,
  parameter int CHID_W = 7,
  parameter int CFG_AW = 4
);
  logic              cfg_n_cs;
  logic              cfg_n_we;
  logic              cfg_n_oe;
  logic [CFG_AW-1:0] cfg_addr;
  logic [15:0]       cfg_din;
  logic [15:0]       cfg_dout;
  logic [CHID_W-1:0] chid_out;
  logic [DATA_W+2:0] data_out;

  modport master (
    output cfg_n_cs, cfg_n_we, cfg_n_oe, cfg_addr, cfg_din,
    input  cfg_dout, chid_out, data_out
  );

  modport slave (
    input  cfg_n_cs, cfg_n_we, cfg_n_oe, cfg_addr, cfg_din,
    output cfg_dout, chid_out, data_out
  );
endinterface

// File: rtl/odu_gen_data_mc.sv
// Multi-channel ODU test-word generator. Channels are served round-robin on
// one output bus; each keeps its own word/row/sequence position so pausing or
// masking a channel resumes exactly where it left off.
module odu_gen_data_mc #(
  parameter int DATA_W = 384,
  parameter int CH_NUM = 4,
  parameter int CHID_W = 7,
  parameter int CFG_AW = 4
) (
  input logic            clk,
  input logic            rst_n,
  odu_gen_data_mc_if.slave bus
);
  localparam int LANES = DATA_W / 16;
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_GAP} state_t;

  // Live configuration registers
  logic              gen_en;
  logic              mode;
  logic [CH_NUM-1:0] ch_en;
  logic [7:0]        wpr;
  logic [3:0]        rpf;
  logic [7:0]        gap;
  logic [15:0]       pat;
  logic [CHID_W-1:0] chid_base;

  logic        cfg_wr, cfg_rd, clr_wr;
  logic [15:0] rd_val;
  logic [15:0] cfg_dout_q;

  // Sequencer state and geometry shadows captured at enable
  state_t      state;
  logic [7:0]  wpr_sh;
  logic [3:0]  rpf_sh;
  logic [7:0]  gap_sh;
  logic        mode_sh;
  logic [7:0]  gap_cnt;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] nxt;
  logic            found;
  int              idx;

  logic [7:0]  w_q   [CH_NUM];
  logic [3:0]  r_q   [CH_NUM];
  logic [15:0] seq_q [CH_NUM];
  logic [15:0] frm_cnt;

  logic [7:0] wpr_eff;
  logic [3:0] rpf_eff;
  logic       w_last, r_last;

  // Output word register
  logic              vld_p1, fs_p1, rs_p1;
  logic [DATA_W-1:0] pay_p1;
  logic [CHID_W-1:0] chid_p1;

  function automatic logic [DATA_W-1:0] build_payload(input logic fixed,
                                                      input logic [15:0] p,
                                                      input logic [15:0] s);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int k = 0; k < LANES; k++) begin
      res[k*16 +: 16] = fixed ? p : (s + 16'(k));
    end
    return res;
  endfunction

  assign cfg_wr = !bus.cfg_n_cs && !bus.cfg_n_we;
  assign cfg_rd = !bus.cfg_n_cs &&  bus.cfg_n_we && !bus.cfg_n_oe;
  assign clr_wr = cfg_wr && (bus.cfg_addr == CFG_AW'(0)) && bus.cfg_din[2];

  // Register file writes; clr is a strobe and is never stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_en    <= 1'b0;
      mode      <= 1'b0;
      ch_en     <= '0;
      wpr       <= 8'd4;
      rpf       <= 4'd4;
      gap       <= '0;
      pat       <= '0;
      chid_base <= '0;
    end else if (cfg_wr) begin
      case (bus.cfg_addr)
        CFG_AW'(0): begin
          gen_en <= bus.cfg_din[0];
          mode   <= bus.cfg_din[1];
        end
        CFG_AW'(1): ch_en     <= bus.cfg_din[CH_NUM-1:0];
        CFG_AW'(2): wpr       <= bus.cfg_din[7:0];
        CFG_AW'(3): rpf       <= bus.cfg_din[3:0];
        CFG_AW'(4): gap       <= bus.cfg_din[7:0];
        CFG_AW'(5): pat       <= bus.cfg_din;
        CFG_AW'(6): chid_base <= bus.cfg_din[CHID_W-1:0];
        default: ;
      endcase
    end
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_val = '0;
    case (bus.cfg_addr)
      CFG_AW'(0): rd_val[1:0]        = {mode, gen_en};
      CFG_AW'(1): rd_val[CH_NUM-1:0] = ch_en;
      CFG_AW'(2): rd_val[7:0]        = wpr;
      CFG_AW'(3): rd_val[3:0]        = rpf;
      CFG_AW'(4): rd_val[7:0]        = gap;
      CFG_AW'(5): rd_val             = pat;
      CFG_AW'(6): rd_val[CHID_W-1:0] = chid_base;
      CFG_AW'(8): rd_val             = frm_cnt;
      CFG_AW'(9): rd_val[0]          = (state != S_IDLE);
      default: ;
    endcase
  end

  // Registered read data, zero whenever no read strobe is present
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_dout_q <= '0;
    else        cfg_dout_q <= cfg_rd ? rd_val : 16'd0;
  end

  // Next enabled channel strictly after the pointer, wrapping back to it last
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    idx   = 0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      if (!found && ch_en[CH_W'(idx)]) begin
        found = 1'b1;
        nxt   = CH_W'(idx);
      end
    end
  end

  assign wpr_eff = (wpr_sh == 8'd0) ? 8'd1 : wpr_sh;
  assign rpf_eff = (rpf_sh == 4'd0) ? 4'd1 : rpf_sh;
  assign w_last  = (w_q[nxt] >= wpr_eff - 8'd1);
  assign r_last  = (r_q[nxt] >= rpf_eff - 4'd1);

  // Sequencer: channel selection, word generation and per-channel bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wpr_sh  <= '0;
      rpf_sh  <= '0;
      gap_sh  <= '0;
      mode_sh <= 1'b0;
      gap_cnt <= '0;
      ptr     <= CH_W'(CH_NUM - 1);
      frm_cnt <= '0;
      vld_p1  <= 1'b0;
      fs_p1   <= 1'b0;
      rs_p1   <= 1'b0;
      pay_p1  <= '0;
      chid_p1 <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        w_q[i]   <= '0;
        r_q[i]   <= '0;
        seq_q[i] <= '0;
      end
    end else begin
      vld_p1 <= 1'b0;
      fs_p1  <= 1'b0;
      rs_p1  <= 1'b0;
      pay_p1 <= '0;
      case (state)
        S_IDLE: begin
          if (gen_en) begin
            wpr_sh  <= wpr;
            rpf_sh  <= rpf;
            gap_sh  <= gap;
            mode_sh <= mode;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!gen_en) begin
            state <= S_IDLE;
          end else if (found) begin
            vld_p1     <= 1'b1;
            rs_p1      <= (w_q[nxt] == 8'd0);
            fs_p1      <= (w_q[nxt] == 8'd0) && (r_q[nxt] == 4'd0);
            pay_p1     <= build_payload(mode_sh, pat, seq_q[nxt]);
            chid_p1    <= chid_base + CHID_W'(nxt);
            ptr        <= nxt;
            seq_q[nxt] <= seq_q[nxt] + 16'd1;
            w_q[nxt]   <= w_last ? 8'd0 : w_q[nxt] + 8'd1;
            if (w_last) begin
              r_q[nxt] <= r_last ? 4'd0 : r_q[nxt] + 4'd1;
              if (r_last) frm_cnt <= frm_cnt + 16'd1;
            end
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (gap_sh != 8'd0) begin
            gap_cnt <= gap_sh - 8'd1;
            state   <= S_GAP;
          end else begin
            state <= S_SCAN;
          end
        end
        S_GAP: begin
          if (!gen_en)               state   <= S_IDLE;
          else if (gap_cnt == 8'd0)  state   <= S_SCAN;
          else                       gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= S_IDLE;
      endcase
      // A clear overrides any bookkeeping update from a word issued this edge
      if (clr_wr) begin
        ptr     <= CH_W'(CH_NUM - 1);
        frm_cnt <= '0;
        for (int i = 0; i < CH_NUM; i++) begin
          w_q[i]   <= '0;
          r_q[i]   <= '0;
          seq_q[i] <= '0;
        end
      end
    end
  end

  assign bus.cfg_dout = cfg_dout_q;
  assign bus.chid_out = chid_p1;
  assign bus.data_out = {vld_p1, fs_p1, rs_p1, pay_p1};
endmodule
